// File: rtl/l1_cache_pkg.sv
// Shared definitions for the split L1 cache model (data and instruction sides):
// MESI state type, trace command codes and default geometry.
package l1_cache_pkg;

   typedef enum logic [1:0] {
      I = 2'd0,
      S = 2'd1,
      E = 2'd2,
      M = 2'd3
   } mesi_t;

   localparam logic [3:0] CMD_RD     = 4'd0;
   localparam logic [3:0] CMD_WR     = 4'd1;
   localparam logic [3:0] CMD_IFETCH = 4'd2;
   localparam logic [3:0] CMD_INV    = 4'd3;
   localparam logic [3:0] CMD_SNOOP  = 4'd4;
   localparam logic [3:0] CMD_CLR    = 4'd8;
   localparam logic [3:0] CMD_PRINT  = 4'd9;

   localparam int DEF_SETS       = 16384;
   localparam int DEF_WAYS       = 4;
   localparam int DEF_LINE_BYTES = 64;

endpackage

// File: rtl/l1_lru_set.sv
// Per-set LRU age update and victim pick: ages form a permutation, 0 = MRU.
module l1_lru_set #(
   parameter int WAYS  = 4,
   parameter int AGE_W = $clog2(WAYS)
) (
   input  logic [WAYS-1:0][AGE_W-1:0] ages_in,
   input  logic [AGE_W-1:0]           acc_way,
   input  logic                       en,
   output logic [WAYS-1:0][AGE_W-1:0] ages_out,
   output logic [AGE_W-1:0]           victim_way
);

   logic [AGE_W-1:0] max_age;
   logic [AGE_W-1:0] acc_age;

   always_comb begin
      ages_out   = ages_in;
      victim_way = '0;
      max_age    = ages_in[0];
      acc_age    = ages_in[acc_way];
      for (int w = 1; w < WAYS; w++) begin
         if (ages_in[w] > max_age) begin
            max_age    = ages_in[w];
            victim_way = AGE_W'(w);
         end
      end
      if (en) begin
         for (int w = 0; w < WAYS; w++) begin
            if (AGE_W'(w) == acc_way)
               ages_out[w] = '0;
            else if (ages_in[w] < acc_age)
               ages_out[w] = ages_in[w] + 1'b1;
         end
      end
   end

endmodule

// File: rtl/l1_cache_data.sv
// Data-side L1 tag/MESI directory with LRU and read/write/hit/miss counters.
// Define CACHE_TRACE_EN to enable simulation trace of L2 messages and statistics.
module l1_cache_data
   import l1_cache_pkg::*;
#(
   parameter int SETS       = DEF_SETS,
   parameter int WAYS       = DEF_WAYS,
   parameter int LINE_BYTES = DEF_LINE_BYTES
) (
   input  logic        Clock,
   input  logic        reset,
   input  logic [3:0]  command,
   input  logic [31:0] tr_addr,
   input  logic        mode,
   input  logic        s,
   output logic [31:0] data_read,
   output logic [31:0] data_write,
   output logic [31:0] data_hit,
   output logic [31:0] data_miss
);

   localparam int OFF_W = $clog2(LINE_BYTES);
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = 32 - OFF_W - IDX_W;
   localparam int AGE_W = $clog2(WAYS);

   function automatic logic [WAYS-1:0][AGE_W-1:0] age_init();
      logic [WAYS-1:0][AGE_W-1:0] r;
      for (int w = 0; w < WAYS; w++) r[w] = AGE_W'(w);
      return r;
   endfunction

   localparam logic [WAYS-1:0][AGE_W-1:0] AGE_INIT = age_init();

   logic [TAG_W-1:0]                  tag_mem [SETS][WAYS];
   logic [SETS-1:0][WAYS-1:0][1:0]    state_mem;
   logic [SETS-1:0][WAYS-1:0][AGE_W-1:0] age_mem;

   logic                       cmd_known;
   logic                       cmd_rw;
   logic [IDX_W-1:0]           idx;
   logic [TAG_W-1:0]           tag;
   logic                       hit;
   logic                       has_inv;
   logic [AGE_W-1:0]           hit_way;
   logic [AGE_W-1:0]           inv_way;
   logic [AGE_W-1:0]           max_way;
   logic [AGE_W-1:0]           acc_way;
   mesi_t                      hit_state;
   logic [WAYS-1:0][AGE_W-1:0] set_ages;
   logic [WAYS-1:0][AGE_W-1:0] new_ages;

   // An X/Z anywhere in the command makes the cycle a no-op.
   assign cmd_known = (^command !== 1'bx);
   assign cmd_rw    = cmd_known && (command == CMD_RD || command == CMD_WR);
   assign idx       = tr_addr[OFF_W +: IDX_W];
   assign tag       = tr_addr[31 -: TAG_W];

   always_comb begin
      hit      = 1'b0;
      has_inv  = 1'b0;
      hit_way  = '0;
      inv_way  = '0;
      set_ages = age_mem[idx];
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (state_mem[idx][w] == I) begin
            has_inv = 1'b1;
            inv_way = AGE_W'(w);
         end else if (tag_mem[idx][w] == tag) begin
            hit     = 1'b1;
            hit_way = AGE_W'(w);
         end
      end
      hit_state = mesi_t'(state_mem[idx][hit_way]);
      acc_way   = hit ? hit_way : (has_inv ? inv_way : max_way);
   end

   l1_lru_set #(.WAYS(WAYS), .AGE_W(AGE_W)) u_lru (
      .ages_in   (set_ages),
      .acc_way   (acc_way),
      .en        (cmd_rw),
      .ages_out  (new_ages),
      .victim_way(max_way)
   );

   always_ff @(posedge Clock or negedge reset) begin
      if (!reset) begin
         state_mem <= '0;
         age_mem   <= {SETS{AGE_INIT}};
      end else if (cmd_known) begin
         case (command)
            CMD_RD, CMD_WR: begin
               age_mem[idx] <= new_ages;
               if (command == CMD_WR)
                  state_mem[idx][acc_way] <= M;
               else if (!hit)
                  state_mem[idx][acc_way] <= E;
            end
            CMD_INV:
               if (hit && hit_state == S) state_mem[idx][hit_way] <= I;
            CMD_SNOOP:
               if (hit && (hit_state == M || hit_state == E)) state_mem[idx][hit_way] <= S;
            CMD_CLR: begin
               state_mem <= '0;
               age_mem   <= {SETS{AGE_INIT}};
            end
            CMD_IFETCH, CMD_PRINT: ;
            default: ;
         endcase
      end
   end

   // Tags need no reset: an invalid way never matches.
   always_ff @(posedge Clock) begin
      if (reset && cmd_rw && !hit) tag_mem[idx][acc_way] <= tag;
   end

   always_ff @(posedge Clock or negedge reset) begin
      if (!reset) begin
         data_read  <= '0;
         data_write <= '0;
         data_hit   <= '0;
         data_miss  <= '0;
      end else if (cmd_known) begin
         if (command == CMD_CLR) begin
            data_read  <= '0;
            data_write <= '0;
            data_hit   <= '0;
            data_miss  <= '0;
         end else if (cmd_rw) begin
            if (command == CMD_RD) data_read  <= data_read + 32'd1;
            else                   data_write <= data_write + 32'd1;
            if (hit) data_hit  <= data_hit + 32'd1;
            else     data_miss <= data_miss + 32'd1;
         end
      end
   end

   logic unused_off;
   assign unused_off = ^tr_addr[OFF_W-1:0];

`ifdef CACHE_TRACE_EN
   logic s_q;
   always_ff @(posedge Clock or negedge reset) begin
      if (!reset) s_q <= 1'b0;
      else        s_q <= s;
   end

   always @(posedge Clock) begin
      if (reset && cmd_known) begin
         if (mode && cmd_rw && !hit) begin
            if (!has_inv && state_mem[idx][max_way] == M)
               $display("Write to L2 %h", {tag_mem[idx][max_way], idx, {OFF_W{1'b0}}});
            if (command == CMD_RD) $display("Read from L2 %h", tr_addr);
            else                   $display("RFO %h", tr_addr);
         end
         if (mode && command == CMD_WR && hit && hit_state == S)
            $display("RFO %h", tr_addr);
         if (mode && command == CMD_SNOOP && hit && hit_state == M)
            $display("Return data to L2 %h", tr_addr);
         if (command == CMD_PRINT)
            for (int st = 0; st < SETS; st++)
               for (int w = 0; w < WAYS; w++)
                  if (state_mem[st][w] != I)
                     $display("set %0d way %0d tag %h %s age %0d", st, w, tag_mem[st][w],
                              mesi_t'(state_mem[st][w]), age_mem[st][w]);
      end
      if (reset && s && !s_q) begin
         $display("reads %0d writes %0d hits %0d misses %0d", data_read, data_write, data_hit, data_miss);
         if ((data_hit + data_miss) == 32'd0) $display("hit ratio 0");
         else $display("hit ratio %f", real'(data_hit) / real'(data_hit + data_miss));
      end
   end
`else
   logic unused_trace;
   assign unused_trace = ^{mode, s};
`endif

endmodule

// File: tb/tb_l1_cache_data.sv
// Directed plus randomized bench for l1_cache_data against a way/recency-list model.
module tb_l1_cache_data;
   import l1_cache_pkg::*;

   localparam int SETS = 16384;
   localparam int WAYS = 4;
   localparam int LINE = 64;

   logic        Clock = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  command = 4'd2;
   logic [31:0] tr_addr = '0;
   logic        mode = 1'b0;
   logic        s = 1'b0;
   logic [31:0] data_read, data_write, data_hit, data_miss;

   int total = 0;
   int bad = 0;

   // Model: per way a state and tag; per set a recency list of way numbers, MRU first.
   mesi_t       mst  [SETS][WAYS];
   logic [11:0] mtag [SETS][WAYS];
   int          rec  [SETS][WAYS];
   logic [31:0] er, ew, eh, em;

   l1_cache_data #(.SETS(SETS), .WAYS(WAYS), .LINE_BYTES(LINE)) dut (
      .Clock(Clock), .reset(reset), .command(command), .tr_addr(tr_addr),
      .mode(mode), .s(s), .data_read(data_read), .data_write(data_write),
      .data_hit(data_hit), .data_miss(data_miss)
   );

   always #5 Clock = ~Clock;

   task automatic m_wipe();
      for (int st = 0; st < SETS; st++)
         for (int w = 0; w < WAYS; w++) begin
            mst[st][w] = I;
            rec[st][w] = w;
         end
      er = 0; ew = 0; eh = 0; em = 0;
   endtask

   task automatic m_touch(int st, int w);
      int p = 0;
      for (int q = 0; q < WAYS; q++) if (rec[st][q] == w) p = q;
      for (int q = p; q > 0; q--) rec[st][q] = rec[st][q-1];
      rec[st][0] = w;
   endtask

   task automatic m_cmd(logic [3:0] c, logic [31:0] a);
      int st, hw, v;
      logic [11:0] tg;
      if ($isunknown(c)) return;
      st = int'(a[19:6]);
      tg = a[31:20];
      hw = -1;
      for (int w = 0; w < WAYS; w++)
         if (mst[st][w] != I && mtag[st][w] == tg) hw = w;
      case (c)
         4'd0, 4'd1: begin
            if (c == 4'd0) er = er + 1; else ew = ew + 1;
            if (hw >= 0) begin
               eh = eh + 1;
               v = hw;
               if (c == 4'd1) mst[st][v] = M;
            end else begin
               em = em + 1;
               v = -1;
               for (int w = WAYS - 1; w >= 0; w--) if (mst[st][w] == I) v = w;
               if (v < 0) v = rec[st][WAYS-1];
               mtag[st][v] = tg;
               mst[st][v]  = (c == 4'd1) ? M : E;
            end
            m_touch(st, v);
         end
         4'd3: if (hw >= 0 && mst[st][hw] == S) mst[st][hw] = I;
         4'd4: if (hw >= 0 && (mst[st][hw] == M || mst[st][hw] == E)) mst[st][hw] = S;
         4'd8: m_wipe();
         default: ;
      endcase
   endtask

   task automatic check(string tag);
      total += 4;
      assert (data_read === er) else begin
         bad++; $error("FAIL %s data_read got %0d exp %0d", tag, data_read, er);
      end
      assert (data_write === ew) else begin
         bad++; $error("FAIL %s data_write got %0d exp %0d", tag, data_write, ew);
      end
      assert (data_hit === eh) else begin
         bad++; $error("FAIL %s data_hit got %0d exp %0d", tag, data_hit, eh);
      end
      assert (data_miss === em) else begin
         bad++; $error("FAIL %s data_miss got %0d exp %0d", tag, data_miss, em);
      end
   endtask

   task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++; $error("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   task automatic step(logic [3:0] c, logic [31:0] a, string tag);
      @(negedge Clock);
      command = c;
      tr_addr = a;
      m_cmd(c, a);
      @(posedge Clock);
      #1;
      check(tag);
      command = CMD_IFETCH;
   endtask

   initial begin
      logic [3:0]  xcmd;
      logic [3:0]  rc;
      logic [31:0] ra;
      m_wipe();
      #1 reset = 1'b0;
      #2;
      check("reset");
      repeat (2) @(posedge Clock);
      @(negedge Clock) reset = 1'b1;

      // Cold read then re-read.
      step(CMD_RD, 32'h0000_0040, "rd_miss");
      step(CMD_RD, 32'h0000_0040, "rd_hit");
      check_val("rd_hit_cnt", data_hit, 32'd1);

      // Write miss then write hit, snoop to S, then invalidate S -> I and re-read misses.
      step(CMD_WR, 32'h1000_0000, "wr_miss");
      step(CMD_WR, 32'h1000_0000, "wr_hit");
      check_val("wr_cnt", data_write, 32'd2);
      step(CMD_SNOOP, 32'h1000_0000, "snoop_m");
      step(CMD_INV, 32'h1000_0000, "inv_s");
      step(CMD_RD, 32'h1000_0000, "rd_after_inv");

      // Clear, then fill set 5 with five tags; the first one is evicted.
      step(CMD_CLR, 32'h0, "clr1");
      for (int k = 0; k < 5; k++) step(CMD_RD, 32'h0000_0140 + k * (SETS * LINE), "fill");
      step(CMD_RD, 32'h0000_0140, "reread_evicted");
      check_val("evict_miss", data_miss, 32'd6);
      step(CMD_RD, 32'h0000_0140 + 4 * (SETS * LINE), "mru_hit");

      // E -> S -> M with RFO; invalidate leaves M so a read hits.
      step(CMD_RD, 32'h2000_0080, "e_fill");
      step(CMD_SNOOP, 32'h2000_0080, "e_snoop");
      step(CMD_WR, 32'h2000_0080, "s_write");
      step(CMD_INV, 32'h2000_0080, "inv_m");
      step(CMD_RD, 32'h2000_0080, "m_still_hit");

      // Clear resets counters and lines.
      step(CMD_CLR, 32'h0, "clr2");
      check_val("clr_read", data_read, 32'd0);
      step(CMD_RD, 32'h2000_0080, "rd_after_clr");

      // Unknown command and instruction fetch are no-ops.
      xcmd = 4'bx;
      step(xcmd, 32'h2000_0080, "cmd_x");
      step(CMD_IFETCH, 32'h2000_0080, "ifetch");

      // Randomized traffic over three sets and eight tags to force evictions.
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 19))
            0, 1, 2, 3, 4, 5: rc = CMD_RD;
            6, 7, 8, 9, 10:   rc = CMD_WR;
            11, 12:           rc = CMD_INV;
            13, 14:           rc = CMD_SNOOP;
            15:               rc = ($urandom_range(0, 3) == 0) ? CMD_CLR : CMD_PRINT;
            16:               rc = CMD_IFETCH;
            default:          rc = 4'($urandom_range(5, 15));
         endcase
         ra = {12'($urandom_range(0, 7)), 14'($urandom_range(0, 2)), 6'($urandom_range(0, 63))};
         step(rc, ra, "random");
      end

      // Asynchronous reset between edges.
      step(CMD_RD, 32'h0000_0040, "pre_reset");
      reset = 1'b0;
      #1;
      m_wipe();
      check("async_reset");
      @(negedge Clock) reset = 1'b1;
      step(CMD_RD, 32'h0000_0040, "rd_after_reset");
      check_val("rd_after_reset_miss", data_miss, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
